// File: rtl/dmem_mmio.sv
// Data-memory subsystem: block RAM below MMIO_BASE, memory-mapped cycle counter,
// LED register, sticky sample status and per-channel sensor sample registers above.
module dmem_mmio #(
   parameter int unsigned                 DATA_WIDTH   = 32,
   parameter int unsigned                 ADDR_WIDTH   = 12,
   parameter logic [ADDR_WIDTH-1:0]       MMIO_BASE    = 12'hF00,
   parameter int unsigned                 NUM_CH       = 4,
   parameter int unsigned                 SAMPLE_WIDTH = 16,
   parameter int unsigned                 OUT_WIDTH    = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           wEn,
   input  logic [ADDR_WIDTH-1:0]          addr,
   input  logic [DATA_WIDTH-1:0]          dataIn,
   output logic [DATA_WIDTH-1:0]          dataOut,
   input  logic [NUM_CH*SAMPLE_WIDTH-1:0] ch_data,
   input  logic [NUM_CH-1:0]              ch_valid,
   output logic [OUT_WIDTH-1:0]           led_out
);

   localparam logic [ADDR_WIDTH-1:0] OFF_CYCLES = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] OFF_LEDS   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(2);
   localparam int unsigned           OFF_SAMPLE = 4;

   logic [DATA_WIDTH-1:0]   r_mem [0:MMIO_BASE-1];
   logic [DATA_WIDTH-1:0]   r_cycles;
   logic [OUT_WIDTH-1:0]    r_leds;
   logic [NUM_CH-1:0]       r_status;
   logic [SAMPLE_WIDTH-1:0] r_sample [NUM_CH];

   logic                    w_is_ram;
   logic [ADDR_WIDTH-1:0]   w_off;
   logic                    w_cyc_wr;
   logic                    w_led_wr;
   logic                    w_st_rd;
   logic                    w_st_wr;
   logic [NUM_CH-1:0]       w_st_clr;
   logic [DATA_WIDTH-1:0]   w_rd_data;

   assign w_is_ram = (addr < MMIO_BASE);
   assign w_off    = addr - MMIO_BASE;
   assign w_cyc_wr = wEn && !w_is_ram && (w_off == OFF_CYCLES);
   assign w_led_wr = wEn && !w_is_ram && (w_off == OFF_LEDS);
   // A write to STATUS is a W1C access, so only a plain read clears everything.
   assign w_st_rd  = !wEn && !w_is_ram && (w_off == OFF_STATUS);
   assign w_st_wr  = wEn && !w_is_ram && (w_off == OFF_STATUS);
   assign led_out  = r_leds;

   always_comb begin
      w_st_clr = '0;
      if (w_st_rd)
         w_st_clr = '1;
      else if (w_st_wr)
         w_st_clr = dataIn[NUM_CH-1:0];
   end

   always_comb begin
      w_rd_data = '0;
      if (w_is_ram) begin
         w_rd_data = r_mem[addr];
      end else begin
         if (w_off == OFF_CYCLES) w_rd_data = r_cycles;
         if (w_off == OFF_LEDS)   w_rd_data = DATA_WIDTH'(r_leds);
         if (w_off == OFF_STATUS) w_rd_data = DATA_WIDTH'(r_status);
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_off == ADDR_WIDTH'(OFF_SAMPLE + i))
               w_rd_data = DATA_WIDTH'(r_sample[i]);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && wEn && w_is_ram)
         r_mem[addr] <= dataIn;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dataOut  <= '0;
         r_cycles <= '0;
         r_leds   <= '0;
         r_status <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++)
            r_sample[i] <= '0;
      end else begin
         dataOut  <= w_rd_data;
         r_cycles <= w_cyc_wr ? dataIn : r_cycles + DATA_WIDTH'(1);
         if (w_led_wr)
            r_leds <= dataIn[OUT_WIDTH-1:0];
         // Set has priority over any clear landing on the same edge.
         r_status <= (r_status & ~w_st_clr) | ch_valid;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i])
               r_sample[i] <= ch_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM read-first behaviour, LEDS, CYCLES wrap,
// STATUS set/clear rules, SAMPLE capture and ignored writes in the MMIO window.
module tb_dmem_mmio;

   logic        clock = 1'b0;
   logic        reset;
   logic        wEn;
   logic [11:0] addr;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic [63:0] ch_data;
   logic [3:0]  ch_valid;
   logic [7:0]  led_out;

   int checks = 0;
   int errors = 0;

   dmem_mmio #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (12),
      .MMIO_BASE   (12'hF00),
      .NUM_CH      (4),
      .SAMPLE_WIDTH(16),
      .OUT_WIDTH   (8)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .wEn     (wEn),
      .addr    (addr),
      .dataIn  (dataIn),
      .dataOut (dataOut),
      .ch_data (ch_data),
      .ch_valid(ch_valid),
      .led_out (led_out)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      wEn = 1'b1; addr = a; dataIn = d;
      step();
      wEn = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a);
      wEn = 1'b0; addr = a;
      step();
   endtask

   initial begin
      reset = 1'b1; wEn = 1'b0; addr = 12'h000; dataIn = '0;
      ch_data = '0; ch_valid = '0;
      step(); step();
      check("reset_dataOut", dataOut, 32'h0);
      check("reset_led", {24'h0, led_out}, 32'h0);

      addr = 12'hF00; reset = 1'b0;
      step();
      check("cycles_after_reset", dataOut, 32'h0);
      step();
      check("cycles_second", dataOut, 32'h1);

      wr(12'h000, 32'hDEADBEEF);
      rd(12'h000);
      check("ram_rd0", dataOut, 32'hDEADBEEF);
      wr(12'h001, 32'h0);
      rd(12'h001);
      check("ram_rd1", dataOut, 32'h0);

      wr(12'h010, 32'h3);
      wr(12'h010, 32'h5);
      check("ram_read_first", dataOut, 32'h3);
      rd(12'h010);
      check("ram_new", dataOut, 32'h5);

      wr(12'hF01, 32'h1A5);
      check("led_out", {24'h0, led_out}, 32'hA5);
      rd(12'hF01);
      check("led_read", dataOut, 32'h000000A5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("led_reset", {24'h0, led_out}, 32'h0);
      check("dout_reset", dataOut, 32'h0);

      wr(12'hF00, 32'hFFFFFFFE);
      rd(12'hF00);
      check("cyc_fffe", dataOut, 32'hFFFFFFFE);
      step();
      check("cyc_ffff", dataOut, 32'hFFFFFFFF);
      step();
      check("cyc_wrap", dataOut, 32'h0);

      addr = 12'h000;
      ch_data = {16'h7777, 16'h8001, 16'hBEEF, 16'h0123};
      ch_valid = 4'b0101;
      step();
      ch_valid = 4'b0000;
      rd(12'hF02);
      check("status_05", dataOut, 32'h5);
      rd(12'hF04);
      check("sample0", dataOut, 32'h00000123);
      rd(12'hF06);
      check("sample2", dataOut, 32'h00008001);
      rd(12'hF05);
      check("sample1_idle", dataOut, 32'h0);
      rd(12'hF02);
      check("status_cleared", dataOut, 32'h0);

      addr = 12'hF02; ch_valid = 4'b0010;
      step();
      ch_valid = 4'b0000;
      check("status_rd_old", dataOut, 32'h0);
      rd(12'hF02);
      check("status_set_wins", dataOut, 32'h2);

      addr = 12'h000; ch_valid = 4'b0101;
      step();
      ch_valid = 4'b0000;
      wr(12'hF02, 32'h1);
      rd(12'hF02);
      check("status_w1c", dataOut, 32'h4);

      wr(12'hF05, 32'h1234);
      wr(12'hF03, 32'h1234);
      wr(12'hFFF, 32'h1234);
      rd(12'hF05);
      check("sample1_ro", dataOut, 32'h0000BEEF);
      rd(12'hF03);
      check("reserved_rd", dataOut, 32'h0);
      rd(12'hFFF);
      check("offff_rd", dataOut, 32'h0);
      wr(12'hEFF, 32'hCAFEF00D);
      rd(12'hEFF);
      check("ram_top", dataOut, 32'hCAFEF00D);
      rd(12'hF04);
      check("sample0_kept", dataOut, 32'h00000123);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
